// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: funct3 access types,
// FSM state encoding and datapath width.
package dmem_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

endpackage

// File: rtl/dmem_align.sv
// Combinational lane logic: store merge into the old word, load extract with
// sign/zero extension, and alignment / illegal-type flags.
module dmem_align
  import dmem_pkg::*;
(
  input  logic [XLEN-1:0] old_word_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [2:0]      type_i,
  input  logic [1:0]      off_i,
  output logic [XLEN-1:0] new_word_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            misalign_o,
  output logic            illegal_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = old_word_i[{off_i, 3'b000} +: 8];
  assign half_sel = off_i[1] ? old_word_i[31:16] : old_word_i[15:0];

  always_comb begin
    new_word_o = old_word_i;
    rdata_o    = '0;
    misalign_o = 1'b0;
    illegal_o  = 1'b0;
    case (type_i)
      F3_B, F3_BU: begin
        new_word_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
        rdata_o = (type_i == F3_B) ? {{24{byte_sel[7]}}, byte_sel} : {24'b0, byte_sel};
      end
      F3_H, F3_HU: begin
        misalign_o = off_i[0];
        new_word_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
        rdata_o = (type_i == F3_H) ? {{16{half_sel[15]}}, half_sel} : {16'b0, half_sel};
      end
      F3_W: begin
        misalign_o = |off_i;
        new_word_o = wdata_i;
        rdata_o    = old_word_i;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: valid/ready request, LATENCY wait states, typed access,
// held response. Define DMEM_BACK2BACK_EN to accept a new request on the response handshake.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int TAM     = 1023,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_store,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [2:0]      req_type,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err
);

  localparam int IW = (TAM > 0) ? $clog2(TAM + 1) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            store_q;
  logic [XLEN-1:0] addr_q, wdata_q;
  logic [2:0]      type_q;
  logic            resp_valid_q, err_q;
  logic [XLEN-1:0] rdata_q;
  logic [XLEN-1:0] mem_q [0:TAM];

  logic            accept, do_access, use_cap, mem_we;
  logic            acc_store, acc_err, oob, misalign, illegal;
  logic [XLEN-1:0] acc_addr, acc_wdata, old_word, new_word, ld_data;
  logic [2:0]      acc_type;
  logic [IW-1:0]   widx;

`ifdef DMEM_BACK2BACK_EN
  assign req_ready = (state_q == ST_IDLE) || ((state_q == ST_RESP) && resp_ready);
`else
  assign req_ready = (state_q == ST_IDLE);
`endif

  assign accept    = req_valid && req_ready;
  assign do_access = ((state_q == ST_WAIT) && (cnt_q == '0)) || (accept && (LATENCY == 0));

  // With zero latency the access happens in the accept cycle, straight off the inputs.
  assign use_cap   = (state_q == ST_WAIT);
  assign acc_store = use_cap ? store_q : req_store;
  assign acc_addr  = use_cap ? addr_q  : req_addr;
  assign acc_wdata = use_cap ? wdata_q : req_wdata;
  assign acc_type  = use_cap ? type_q  : req_type;

  assign widx     = acc_addr[IW+1:2];
  assign oob      = acc_addr[XLEN-1:2] > 30'(TAM);
  assign old_word = mem_q[widx];
  assign acc_err  = misalign || illegal || oob || (acc_store && acc_type[2]);
  assign mem_we   = do_access && acc_store && !acc_err && !reset;

  dmem_align u_align (
    .old_word_i (old_word),
    .wdata_i    (acc_wdata),
    .type_i     (acc_type),
    .off_i      (acc_addr[1:0]),
    .new_word_o (new_word),
    .rdata_o    (ld_data),
    .misalign_o (misalign),
    .illegal_o  (illegal)
  );

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[widx] <= new_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      store_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      type_q       <= '0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_WAIT: if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        ST_RESP: if (resp_ready) begin
          resp_valid_q <= 1'b0;
          state_q      <= ST_IDLE;
        end
        default: ;
      endcase
      if (accept) begin
        store_q <= req_store;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        type_q  <= req_type;
        if (LATENCY == 0) state_q <= ST_RESP;
        else begin
          cnt_q   <= CW'(LATENCY - 1);
          state_q <= ST_WAIT;
        end
      end
      if (do_access) begin
        rdata_q      <= (acc_store || acc_err) ? '0 : ld_data;
        err_q        <= acc_err;
        resp_valid_q <= 1'b1;
        state_q      <= ST_RESP;
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: byte-level memory model checked every cycle,
// plus directed transactions with literal expectations.
module tb_data_mem_responder;

  localparam int LAT = 2;
  localparam int TAM = 1023;
`ifdef DMEM_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic        clk = 1'b0, reset = 1'b1;
  logic        req_valid, req_ready, req_store, resp_valid, resp_ready, resp_err;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic [2:0]  req_type;

  data_mem_responder #(.TAM(TAM), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_type(req_type),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Byte-addressed reference memory; untouched bytes read as zero.
  logic [7:0] mb [longint];

  function automatic void model_do(input bit st, input logic [31:0] a, input logic [31:0] wd,
                                   input logic [2:0] ty, output logic [31:0] rd, output bit er);
    int sz = 1;
    bit sgn = 1'b0, legal = 1'b1;
    logic [31:0] v = '0;
    case (ty)
      3'b000: begin sz = 1; sgn = 1'b1; end
      3'b001: begin sz = 2; sgn = 1'b1; end
      3'b010: sz = 4;
      3'b100: sz = 1;
      3'b101: sz = 2;
      default: legal = 1'b0;
    endcase
    er = !legal || ((a % sz) != 0) || ((a >> 2) > TAM) || (st && (ty == 3'b100 || ty == 3'b101));
    rd = '0;
    if (!er) begin
      if (st) begin
        for (int i = 0; i < sz; i++) mb[longint'(a) + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < sz; i++)
          v = v | ((mb.exists(longint'(a) + i) ? 32'(mb[longint'(a) + i]) : 32'd0) << (8*i));
        if (sgn && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
        rd = v;
      end
    end
  endfunction

  // Reference state: one outstanding request, response due LAT+1 cycles after accept.
  bit          m_rv = 1'b0, m_pend = 1'b0, m_err = 1'b0, prev_rv = 1'b0;
  logic [31:0] m_rd = '0;
  int          m_due = 0, cyc = 0, acc_cnt = 0;
  bit          p_st;
  logic [31:0] p_a, p_wd;
  logic [2:0]  p_ty;
  int          rise_q[$];

  always @(negedge clk) begin
    bit rr;
    cyc++;
    if (reset) begin
      m_rv = 1'b0; m_pend = 1'b0; m_rd = '0; m_err = 1'b0;
    end else if (m_pend && cyc == m_due) begin
      model_do(p_st, p_a, p_wd, p_ty, m_rd, m_err);
      m_rv = 1'b1;
      m_pend = 1'b0;
    end
    rr = !m_pend && (!m_rv || (B2B && resp_ready));
    chk("resp_valid", 32'(resp_valid), 32'(m_rv));
    chk("resp_rdata", resp_rdata, m_rd);
    chk("resp_err", 32'(resp_err), 32'(m_err));
    chk("req_ready", 32'(req_ready), 32'(rr));
    if (resp_valid && !prev_rv) rise_q.push_back(cyc);
    prev_rv = resp_valid;
    if (!reset) begin
      if (m_rv && resp_ready) m_rv = 1'b0;
      if (req_valid && rr) begin
        p_st = req_store; p_a = req_addr; p_wd = req_wdata; p_ty = req_type;
        m_pend = 1'b1;
        m_due = cyc + LAT + 1;
        acc_cnt++;
      end
    end
  end

  task automatic wait_accept(input string nm);
    int base = acc_cnt, n = 0;
    while (acc_cnt == base && n < 20) begin @(posedge clk); #1; n++; end
    req_valid = 1'b0;
    chk({nm, " accepted"}, 32'(acc_cnt - base), 32'd1);
  endtask

  task automatic xact(input bit st, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] ty,
                      input logic [31:0] erd, input bit eer, input string nm, input int hold);
    int lat = 0;
    logic [31:0] held;
    @(posedge clk); #1;
    if (hold > 0) resp_ready = 1'b0;
    req_valid = 1'b1; req_store = st; req_addr = a; req_wdata = wd; req_type = ty;
    wait_accept(nm);
    do begin @(negedge clk); lat++; end while (!resp_valid && lat < 20);
    chk({nm, " latency"}, 32'(lat), 32'(LAT + 1));
    chk({nm, " rdata"}, resp_rdata, erd);
    chk({nm, " err"}, 32'(resp_err), 32'(eer));
    if (hold > 0) begin
      held = resp_rdata;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        req_valid = 1'b1; req_store = 1'b1; req_addr = 32'h14; req_wdata = 32'h0BAD_0BAD; req_type = 3'b010;
        @(negedge clk);
        chk({nm, " held valid"}, 32'(resp_valid), 32'd1);
        chk({nm, " held rdata"}, resp_rdata, held);
        chk({nm, " held req_ready"}, 32'(req_ready), 32'd0);
      end
      @(posedge clk); #1;
      req_valid = 1'b0; resp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk({nm, " released valid"}, 32'(resp_valid), 32'd0);
      chk({nm, " released req_ready"}, 32'(req_ready), 32'd1);
    end
  endtask

  initial begin
    int base, rbase, n;
    req_valid = 1'b0; req_store = 1'b0; req_addr = '0; req_wdata = '0; req_type = '0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset rdata", resp_rdata, 32'd0);
    reset = 1'b0;

    xact(1, 32'h10, 32'hDEAD_BEEF, 3'b010, 32'h0, 0, "SW 0x10", 0);
    xact(0, 32'h10, 32'h0, 3'b010, 32'hDEAD_BEEF, 0, "LW 0x10", 0);
    xact(1, 32'h11, 32'h0000_00AA, 3'b000, 32'h0, 0, "SB 0x11", 0);
    xact(0, 32'h10, 32'h0, 3'b010, 32'hDEAD_AAEF, 0, "LW 0x10 merged", 0);
    xact(0, 32'h11, 32'h0, 3'b000, 32'hFFFF_FFAA, 0, "LB 0x11", 0);
    xact(0, 32'h11, 32'h0, 3'b100, 32'h0000_00AA, 0, "LBU 0x11", 0);
    xact(0, 32'h12, 32'h0, 3'b101, 32'h0000_DEAD, 0, "LHU 0x12", 0);

    xact(0, 32'h12, 32'h0, 3'b010, 32'h0, 1, "LW misaligned", 0);
    xact(0, 32'h13, 32'h0, 3'b001, 32'h0, 1, "LH misaligned", 0);
    xact(0, 32'h1000, 32'h0, 3'b010, 32'h0, 1, "LW out of range", 0);
    xact(0, 32'h10, 32'h0, 3'b011, 32'h0, 1, "type 011", 0);
    xact(1, 32'h10, 32'h1111_1111, 3'b100, 32'h0, 1, "store BU", 0);
    xact(0, 32'h10, 32'h0, 3'b010, 32'hDEAD_AAEF, 0, "LW 0x10 unchanged", 0);

    xact(1, 32'h14, 32'h1122_3344, 3'b010, 32'h0, 0, "SW 0x14", 0);
    xact(1, 32'h16, 32'hAAAA_5678, 3'b001, 32'h0, 0, "SH 0x16", 0);
    xact(0, 32'h14, 32'h0, 3'b010, 32'h5678_3344, 0, "LW 0x14", 0);
    xact(0, 32'h16, 32'h0, 3'b001, 32'h0000_5678, 0, "LH 0x16", 0);

    xact(0, 32'h10, 32'h0, 3'b010, 32'hDEAD_AAEF, 0, "LW hold", 5);
    xact(0, 32'h14, 32'h0, 3'b010, 32'h5678_3344, 0, "LW after hold", 0);

    // Reset during the wait of a store: the store must be dropped.
    xact(1, 32'h20, 32'hCAFE_F00D, 3'b010, 32'h0, 0, "SW 0x20", 0);
    @(posedge clk); #1;
    req_valid = 1'b1; req_store = 1'b1; req_addr = 32'h20; req_wdata = 32'h1234_5678; req_type = 3'b010;
    wait_accept("SW 0x20 dropped");
    reset = 1'b1;
    #1;
    chk("mid reset resp_valid", 32'(resp_valid), 32'd0);
    chk("mid reset req_ready", 32'(req_ready), 32'd1);
    chk("mid reset err", 32'(resp_err), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    xact(0, 32'h20, 32'h0, 3'b010, 32'hCAFE_F00D, 0, "LW 0x20 after reset", 0);

    // Streaming loads: spacing shows whether back-to-back capture is enabled.
    @(posedge clk); #1;
    req_valid = 1'b1; req_store = 1'b0; req_addr = 32'h10; req_type = 3'b010;
    base = acc_cnt;
    rbase = rise_q.size();
    n = 0;
    while (acc_cnt < base + 4 && n < 100) begin @(posedge clk); #1; n++; end
    req_valid = 1'b0;
    n = 0;
    while (rise_q.size() < rbase + 4 && n < 50) begin @(negedge clk); n++; end
    chk("stream responses", 32'(rise_q.size() - rbase), 32'd4);
    if (rise_q.size() >= rbase + 4)
      for (int i = 1; i < 4; i++)
        chk("stream spacing", 32'(rise_q[rbase+i] - rise_q[rbase+i-1]), B2B ? 32'(LAT + 1) : 32'(LAT + 2));
    repeat (4) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
